// File: rtl/mem_stage.sv
// Pipeline memory stage: issues data-cache requests, aligns and extends load data,
// stalls upstream while an access is outstanding, and owns the MEM/WB register.
package mem_stage_pkg;
  typedef struct packed {
    logic [31:0] raw;
    logic [4:0]  rd;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
  } decoded_inst_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ex_is_bubble,
  input  decoded_inst_t ex_inst,
  input  logic [63:0]   ex_alu_result,
  input  logic [63:0]   ex_store_data,
  input  logic          wb_stall,
  input  logic          flush,
  output logic          mem_stall,
  output logic          req_valid,
  input  logic          req_ready,
  output logic [63:0]   req_addr,
  output logic          req_we,
  output logic [63:0]   req_wdata,
  output logic [7:0]    req_wstrb,
  input  logic          resp_valid,
  input  logic [63:0]   resp_data,
  output logic          misaligned,
  output logic          wb_is_bubble,
  output decoded_inst_t wb_inst,
  output logic [63:0]   wb_alu_result,
  output logic [63:0]   wb_mem_result
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          done_s;
  logic          mem_op_s;
  logic [2:0]    off_s;
  logic [5:0]    shamt_s;
  logic [3:0]    bytes_s;
  logic [7:0]    base_strb_s;
  logic          cross_s;
  logic [63:0]   shifted_s;
  logic [63:0]   load_ext_s;
  logic [63:0]   mem_res_s;

  logic          wb_bubble_q;
  decoded_inst_t wb_inst_q;
  logic [63:0]   wb_alu_q;
  logic [63:0]   wb_mem_q;
  logic          buf_bubble_q;
  decoded_inst_t buf_inst_q;
  logic [63:0]   buf_alu_q;
  logic [63:0]   buf_mem_q;

  // Access decode, request formatting and load-data extraction
  always_comb begin
    mem_op_s  = !ex_is_bubble && (ex_inst.is_load || ex_inst.is_store);
    off_s     = ex_alu_result[2:0];
    shamt_s   = {off_s, 3'b000};
    shifted_s = resp_data >> shamt_s;
    case (ex_inst.funct3[1:0])
      2'd0: begin
        bytes_s     = 4'd1;
        base_strb_s = 8'h01;
        load_ext_s  = ex_inst.funct3[2] ? {56'd0, shifted_s[7:0]}
                                        : {{56{shifted_s[7]}}, shifted_s[7:0]};
      end
      2'd1: begin
        bytes_s     = 4'd2;
        base_strb_s = 8'h03;
        load_ext_s  = ex_inst.funct3[2] ? {48'd0, shifted_s[15:0]}
                                        : {{48{shifted_s[15]}}, shifted_s[15:0]};
      end
      2'd2: begin
        bytes_s     = 4'd4;
        base_strb_s = 8'h0F;
        load_ext_s  = ex_inst.funct3[2] ? {32'd0, shifted_s[31:0]}
                                        : {{32{shifted_s[31]}}, shifted_s[31:0]};
      end
      default: begin
        bytes_s     = 4'd8;
        base_strb_s = 8'hFF;
        load_ext_s  = shifted_s;
      end
    endcase
    cross_s   = ({1'b0, off_s} + bytes_s) > 4'd8;
    req_addr  = {ex_alu_result[63:3], 3'b000};
    req_we    = ex_inst.is_store;
    req_wdata = ex_store_data << shamt_s;
    req_wstrb = base_strb_s << off_s;
    if (!ex_is_bubble && ex_inst.is_load) begin
      mem_res_s = load_ext_s;
    end else begin
      mem_res_s = 64'd0;
    end
  end

  // Handshake control, completion detection and stall generation
  always_comb begin
    req_valid = 1'b0;
    done_s    = 1'b0;
    state_d   = state_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op_s) begin
          req_valid = !flush;
          if (req_ready) begin
            if (ex_inst.is_store) begin
              done_s = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d = S_REQ;
          end
        end else begin
          done_s = 1'b1;
        end
      end
      S_REQ: begin
        req_valid = !flush;
        if (req_ready) begin
          if (ex_inst.is_store) begin
            done_s = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          done_s = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!wb_stall) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (resp_valid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (done_s) begin
      state_d = wb_stall ? S_HOLD : S_IDLE;
    end else begin
      state_d = state_d;
    end

    // A response still owed by the cache must be swallowed before reuse
    if (flush) begin
      if ((state_q == S_WAIT || state_q == S_DRAIN) && !resp_valid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_IDLE;
      end
      mem_stall = (state_d == S_DRAIN);
    end else begin
      mem_stall = !((done_s || state_q == S_HOLD) && !wb_stall);
    end

    misaligned = mem_op_s && cross_s && (state_q == S_IDLE);

    if (reset) begin
      req_valid  = 1'b0;
      mem_stall  = 1'b0;
      misaligned = 1'b0;
    end else begin
      req_valid  = req_valid;
    end
  end

  // State, completion buffer and MEM/WB register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wb_bubble_q  <= 1'b1;
      wb_inst_q    <= '0;
      wb_alu_q     <= 64'd0;
      wb_mem_q     <= 64'd0;
      buf_bubble_q <= 1'b1;
      buf_inst_q   <= '0;
      buf_alu_q    <= 64'd0;
      buf_mem_q    <= 64'd0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wb_bubble_q <= 1'b1;
      end else if (done_s && !wb_stall) begin
        wb_bubble_q <= ex_is_bubble;
        wb_inst_q   <= ex_inst;
        wb_alu_q    <= ex_alu_result;
        wb_mem_q    <= mem_res_s;
      end else if (state_q == S_HOLD && !wb_stall) begin
        wb_bubble_q <= buf_bubble_q;
        wb_inst_q   <= buf_inst_q;
        wb_alu_q    <= buf_alu_q;
        wb_mem_q    <= buf_mem_q;
      end
      if (done_s && wb_stall && !flush) begin
        buf_bubble_q <= ex_is_bubble;
        buf_inst_q   <= ex_inst;
        buf_alu_q    <= ex_alu_result;
        buf_mem_q    <= mem_res_s;
      end
    end
  end

  assign wb_is_bubble  = wb_bubble_q;
  assign wb_inst       = wb_inst_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_mem_result = wb_mem_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed expectations checked with immediate assertions.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_is_bubble;
  decoded_inst_t ex_inst;
  logic [63:0]   ex_alu_result;
  logic [63:0]   ex_store_data;
  logic          wb_stall;
  logic          flush;
  logic          mem_stall;
  logic          req_valid;
  logic          req_ready;
  logic [63:0]   req_addr;
  logic          req_we;
  logic [63:0]   req_wdata;
  logic [7:0]    req_wstrb;
  logic          resp_valid;
  logic [63:0]   resp_data;
  logic          misaligned;
  logic          wb_is_bubble;
  decoded_inst_t wb_inst;
  logic [63:0]   wb_alu_result;
  logic [63:0]   wb_mem_result;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage dut (
    .clk(clk), .reset(reset), .ex_is_bubble(ex_is_bubble), .ex_inst(ex_inst),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .wb_stall(wb_stall), .flush(flush), .mem_stall(mem_stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_data(resp_data), .misaligned(misaligned),
    .wb_is_bubble(wb_is_bubble), .wb_inst(wb_inst),
    .wb_alu_result(wb_alu_result), .wb_mem_result(wb_mem_result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_op(input logic bub, input logic ld, input logic st,
                        input logic [2:0] f3, input logic [63:0] alu, input logic [63:0] sd);
    ex_is_bubble    = bub;
    ex_inst.raw     = 32'h0000_0013;
    ex_inst.rd      = 5'd10;
    ex_inst.is_load = ld;
    ex_inst.is_store = st;
    ex_inst.funct3  = f3;
    ex_alu_result   = alu;
    ex_store_data   = sd;
  endtask

  initial begin
    reset = 1'b1; wb_stall = 1'b0; flush = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = 64'd0;
    set_op(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    tick(); tick();
    settle();
    chk("rst_bubble", {63'd0, wb_is_bubble}, 64'd1);
    chk("rst_alu", wb_alu_result, 64'd0);
    chk("rst_mem", wb_mem_result, 64'd0);
    chk("rst_inst", {22'd0, wb_inst}, 64'd0);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_mem_stall", {63'd0, mem_stall}, 64'd0);
    reset = 1'b0;
    tick();

    // ADD
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'h1234, 64'd0);
    settle();
    chk("add_stall", {63'd0, mem_stall}, 64'd0);
    chk("add_req_valid", {63'd0, req_valid}, 64'd0);
    tick();
    chk("add_wb_alu", wb_alu_result, 64'h1234);
    chk("add_wb_bubble", {63'd0, wb_is_bubble}, 64'd0);
    chk("add_wb_rd", {59'd0, wb_inst.rd}, 64'd10);

    // LB at 0x1005
    set_op(1'b0, 1'b1, 1'b0, 3'b000, 64'h1005, 64'd0);
    req_ready = 1'b1;
    settle();
    chk("lb_req_valid", {63'd0, req_valid}, 64'd1);
    chk("lb_req_addr", req_addr, 64'h1000);
    chk("lb_req_we", {63'd0, req_we}, 64'd0);
    chk("lb_stall_acc", {63'd0, mem_stall}, 64'd1);
    tick();
    req_ready = 1'b0; resp_valid = 1'b1; resp_data = 64'h0000_8000_0000_0000;
    settle();
    chk("lb_stall_resp", {63'd0, mem_stall}, 64'd0);
    tick();
    resp_valid = 1'b0;
    chk("lb_wb_mem", wb_mem_result, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_wb_alu", wb_alu_result, 64'h1005);

    // LBU same access
    set_op(1'b0, 1'b1, 1'b0, 3'b100, 64'h1005, 64'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    chk("lbu_wb_mem", wb_mem_result, 64'h80);

    // SH at 0x2002
    set_op(1'b0, 1'b0, 1'b1, 3'b001, 64'h2002, 64'hABCD);
    req_ready = 1'b1;
    settle();
    chk("sh_wstrb", {56'd0, req_wstrb}, 64'h0C);
    chk("sh_wdata", req_wdata, 64'hABCD_0000);
    chk("sh_we", {63'd0, req_we}, 64'd1);
    chk("sh_stall", {63'd0, mem_stall}, 64'd0);
    chk("sh_misaligned", {63'd0, misaligned}, 64'd0);
    tick();
    chk("sh_wb_mem", wb_mem_result, 64'd0);
    chk("sh_wb_alu", wb_alu_result, 64'h2002);

    // SW at 0x2006 crosses the doubleword
    set_op(1'b0, 1'b0, 1'b1, 3'b010, 64'h2006, 64'h1122_3344);
    settle();
    chk("sw_misaligned", {63'd0, misaligned}, 64'd1);
    chk("sw_wstrb", {56'd0, req_wstrb}, 64'hC0);
    chk("sw_wdata", req_wdata, 64'h3344_0000_0000_0000);
    tick();
    chk("sw_wb_alu", wb_alu_result, 64'h2006);

    // LD with late ready, late response and writeback stall
    set_op(1'b0, 1'b1, 1'b0, 3'b011, 64'h3008, 64'd0);
    req_ready = 1'b0;
    settle();
    chk("ld_a_valid", {63'd0, req_valid}, 64'd1);
    chk("ld_a_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    settle();
    chk("ld_b_valid", {63'd0, req_valid}, 64'd1);
    chk("ld_b_addr", req_addr, 64'h3008);
    chk("ld_b_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    req_ready = 1'b1;
    settle();
    chk("ld_c_valid", {63'd0, req_valid}, 64'd1);
    chk("ld_c_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    req_ready = 1'b0;
    settle();
    chk("ld_d_stall", {63'd0, mem_stall}, 64'd1);
    chk("ld_d_valid", {63'd0, req_valid}, 64'd0);
    tick();
    settle();
    chk("ld_e_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    resp_valid = 1'b1; resp_data = 64'h0123_4567_89AB_CDEF; wb_stall = 1'b1;
    settle();
    chk("ld_f_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    resp_valid = 1'b0; resp_data = 64'd0;
    settle();
    chk("ld_g_stall", {63'd0, mem_stall}, 64'd1);
    chk("ld_g_wb_alu", wb_alu_result, 64'h2006);
    tick();
    settle();
    chk("ld_h_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    wb_stall = 1'b0;
    settle();
    chk("ld_i_stall", {63'd0, mem_stall}, 64'd0);
    chk("ld_i_wb_alu", wb_alu_result, 64'h2006);
    tick();
    chk("ld_wb_mem", wb_mem_result, 64'h0123_4567_89AB_CDEF);
    chk("ld_wb_alu", wb_alu_result, 64'h3008);

    // LW flushed in WAIT
    set_op(1'b0, 1'b1, 1'b0, 3'b010, 64'h4004, 64'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; flush = 1'b1;
    settle();
    chk("fw_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    flush = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'h5555, 64'd0);
    chk("fw_wb_bubble", {63'd0, wb_is_bubble}, 64'd1);
    settle();
    chk("fw_drain_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    resp_valid = 1'b1; resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    settle();
    chk("fw_drain_resp_stall", {63'd0, mem_stall}, 64'd1);
    tick();
    resp_valid = 1'b0;
    chk("fw_after_bubble", {63'd0, wb_is_bubble}, 64'd1);
    settle();
    chk("fw_next_stall", {63'd0, mem_stall}, 64'd0);
    tick();
    chk("fw_next_alu", wb_alu_result, 64'h5555);
    chk("fw_next_bubble", {63'd0, wb_is_bubble}, 64'd0);
    chk("fw_next_mem", wb_mem_result, 64'd0);

    // LW flushed in REQ
    set_op(1'b0, 1'b1, 1'b0, 3'b010, 64'h4100, 64'd0);
    req_ready = 1'b0;
    tick();
    flush = 1'b1; req_ready = 1'b1;
    settle();
    chk("fr_req_valid", {63'd0, req_valid}, 64'd0);
    tick();
    flush = 1'b0; req_ready = 1'b0;
    set_op(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    chk("fr_wb_bubble", {63'd0, wb_is_bubble}, 64'd1);
    settle();
    chk("fr_idle_valid", {63'd0, req_valid}, 64'd0);
    chk("fr_idle_stall", {63'd0, mem_stall}, 64'd0);
    tick();

    // Reset during WAIT
    set_op(1'b0, 1'b1, 1'b0, 3'b011, 64'h6000, 64'd0);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0; reset = 1'b1;
    set_op(1'b1, 1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("rw_bubble", {63'd0, wb_is_bubble}, 64'd1);
    chk("rw_alu", wb_alu_result, 64'd0);
    chk("rw_mem", wb_mem_result, 64'd0);
    chk("rw_inst", {22'd0, wb_inst}, 64'd0);
    chk("rw_valid", {63'd0, req_valid}, 64'd0);
    chk("rw_stall", {63'd0, mem_stall}, 64'd0);
    resp_valid = 1'b1; resp_data = 64'h1111_2222_3333_4444;
    tick();
    resp_valid = 1'b0;
    chk("rw_stray_resp_mem", wb_mem_result, 64'd0);

    // Flush and wb_stall together
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'h77, 64'd0);
    tick();
    chk("fs_prev_alu", wb_alu_result, 64'h77);
    set_op(1'b0, 1'b0, 1'b0, 3'd0, 64'h88, 64'd0);
    wb_stall = 1'b1; flush = 1'b1;
    tick();
    chk("fs_bubble", {63'd0, wb_is_bubble}, 64'd1);
    chk("fs_alu_kept", wb_alu_result, 64'h77);
    wb_stall = 1'b0; flush = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
